// File: rtl/aes_seq_pkg.sv
// Shared types for the AES request sequencer: FSM states, result status codes
// and the AES block width.
package aes_seq_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RETRY  = 3'd3,
        S_RESP   = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_RETRY_OK = 2'b01,
        ST_FAULT    = 2'b10,
        ST_TIMEOUT  = 2'b11
    } seq_status_t;

endpackage

// File: rtl/aes_req_sequencer.sv
// Request/response front-end for the hardened AES-128 core. Takes one
// key/plaintext request at a time, pulses the core, retries a bounded number
// of times on a fault alert, aborts on timeout, and returns ciphertext plus a
// status code. All secret-bearing registers are cleared after each result
// handshake.
module aes_req_sequencer
    import aes_seq_pkg::*;
#(
    parameter int MAX_RETRY      = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ERRW           = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_key,
    input  logic [AES_BLOCK_W-1:0] in_plain,
    output logic                   core_start,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic [AES_BLOCK_W-1:0] core_plain,
    input  logic [AES_BLOCK_W-1:0] core_ciphertext,
    input  logic                   core_valid,
    input  logic                   core_busy,
    input  logic                   core_fault,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic [1:0]             out_status,
    output logic [ERRW-1:0]        err_count
);

    // Counter widths; a zero retry budget still needs a 1-bit counter.
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t             state, state_nxt;
    logic [AES_BLOCK_W-1:0] key_r, plain_r, data_r;
    seq_status_t            status_r;
    logic [ERRW-1:0]        err_r;
    logic [RW-1:0]          retry_cnt;
    logic [TW-1:0]          timer;

    // Control strobes from the FSM to the datapath.
    logic                   capture, retry_inc, timer_clr, timer_inc;
    logic                   load_res, rsp_done;
    logic [AES_BLOCK_W-1:0] res_data;
    seq_status_t            res_status;

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    assign core_key   = key_r;
    assign core_plain = plain_r;
    assign out_data   = data_r;
    assign out_status = status_r;
    assign err_count  = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, Moore handshake outputs and datapath strobes.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        capture    = 1'b0;
        retry_inc  = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        load_res   = 1'b0;
        rsp_done   = 1'b0;
        res_data   = '0;
        res_status = ST_OK;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    timer_clr  = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A fault alert overrides a same-cycle result: the data may be
                // the product of a corrupted computation.
                if (core_fault) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_inc = 1'b1;
                        state_nxt = S_RETRY;
                    end else begin
                        load_res   = 1'b1;
                        res_status = ST_FAULT;
                        state_nxt  = S_RESP;
                    end
                end else if (core_valid) begin
                    load_res   = 1'b1;
                    res_data   = core_ciphertext;
                    res_status = (retry_cnt == '0) ? ST_OK : ST_RETRY_OK;
                    state_nxt  = S_RESP;
                end else if (timer == TIMER_LAST) begin
                    load_res   = 1'b1;
                    res_status = ST_TIMEOUT;
                    state_nxt  = S_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_RETRY: begin
                // One quiet cycle so the core can drop its alert.
                state_nxt = S_LAUNCH;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request/result registers, counters and zeroization.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r     <= '0;
            plain_r   <= '0;
            data_r    <= '0;
            status_r  <= ST_OK;
            err_r     <= '0;
            retry_cnt <= '0;
            timer     <= '0;
        end else begin
            if (capture) begin
                key_r     <= in_key;
                plain_r   <= in_plain;
                retry_cnt <= '0;
            end
            if (retry_inc) retry_cnt <= retry_cnt + RW'(1);
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + TW'(1);
            if (load_res) begin
                data_r   <= res_data;
                status_r <= res_status;
            end
            if (rsp_done) begin
                data_r  <= '0;
                key_r   <= '0;
                plain_r <= '0;
                if (status_r == ST_FAULT || status_r == ST_TIMEOUT)
                    err_r <= sat_inc(err_r);
            end
        end
    end

endmodule

// File: tb/tb_aes_req_sequencer.sv
// Directed bench for aes_req_sequencer. The core side is a behavioural stand-in
// driven from the stimulus process; ciphertexts are the FIPS-197 / SP800-38A
// known answers for the keys used.
module tb_aes_req_sequencer;

    localparam int ERRW = 2;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [127:0]    in_key, in_plain;
    logic            core_start;
    logic [127:0]    core_key, core_plain, core_ciphertext;
    logic            core_valid, core_busy, core_fault;
    logic            out_valid, out_ready;
    logic [127:0]    out_data;
    logic [1:0]      out_status;
    logic [ERRW-1:0] err_count;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int nstart  = 0;

    aes_req_sequencer #(
        .MAX_RETRY      (1),
        .TIMEOUT_CYCLES (16),
        .ERRW           (ERRW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_key          (in_key),
        .in_plain        (in_plain),
        .core_start      (core_start),
        .core_key        (core_key),
        .core_plain      (core_plain),
        .core_ciphertext (core_ciphertext),
        .core_valid      (core_valid),
        .core_busy       (core_busy),
        .core_fault      (core_fault),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_status      (out_status),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    // Cycle counter and start-pulse counter.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (core_start) nstart <= nstart + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request from IDLE; returns just after the accepting edge.
    task automatic send_req(input logic [127:0] k, input logic [127:0] p);
        step();
        in_key = k; in_plain = p; in_valid = 1'b1;
        @(negedge clk);
        check_eq("req_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Wait for a start pulse; returns in the first WAIT cycle.
    task automatic wait_start(input int budget, output int start_at);
        bit ok;
        ok = 1'b0;
        start_at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (core_start) begin ok = 1'b1; start_at = cyc; end
            step();
        end
        check_eq("start_seen", ok, 1);
    endtask

    // Core answers after lat WAIT cycles with a one-cycle valid/fault.
    task automatic core_reply(input int lat, input logic v, input logic f, input logic [127:0] c);
        repeat (lat) step();
        core_valid = v; core_fault = f; core_ciphertext = c;
        step();
        core_valid = 1'b0; core_fault = 1'b0; core_ciphertext = '0;
    endtask

    // Wait for out_valid; returns at the negedge of the first RESP cycle.
    task automatic wait_out(input int budget, output int out_at);
        bit ok;
        ok = 1'b0;
        out_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; out_at = cyc; break; end
            step();
        end
        check_eq("out_seen", ok, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_timeout(output int s, output int o);
        send_req(K1, P1);
        wait_start(20, s);
        wait_out(40, o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, s, o, acc;
        bit seen_out, seen_start;
        rst = 1'b1; in_valid = 1'b0; in_key = '0; in_plain = '0;
        core_ciphertext = '0; core_valid = 1'b0; core_busy = 1'b0; core_fault = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_status", out_status, 0);
        check_eq("rst_err", err_count, 0);
        check_eq("rst_core_key", core_key, 0);

        // Plain success on the first attempt.
        send_req(K1, P1);
        base = nstart;
        wait_start(20, s);
        check_eq("t1_core_key", core_key, K1);
        check_eq("t1_core_plain", core_plain, P1);
        core_reply(5, 1, 0, C1);
        wait_out(20, o);
        check_eq("t1_data", out_data, C1);
        check_eq("t1_status", out_status, 2'b00);
        check_eq("t1_starts", nstart - base, 1);
        handshake();
        check_eq("t1_err", err_count, 0);
        check_eq("t1_zero_data", out_data, 0);
        check_eq("t1_zero_key", core_key, 0);
        check_eq("t1_zero_plain", core_plain, 0);
        check_eq("t1_out_valid", out_valid, 0);
        check_eq("t1_in_ready", in_ready, 1);

        // Fault on the first attempt, success on the retry.
        send_req(K2, P2);
        base = nstart;
        wait_start(20, s);
        core_reply(3, 0, 1, '0);
        wait_start(20, s);
        check_eq("t2_retry_key", core_key, K2);
        core_reply(4, 1, 0, C2);
        wait_out(20, o);
        check_eq("t2_data", out_data, C2);
        check_eq("t2_status", out_status, 2'b01);
        check_eq("t2_starts", nstart - base, 2);
        handshake();
        check_eq("t2_err", err_count, 0);

        // Fault on both attempts; second fault arrives together with valid.
        send_req(K2, P2);
        base = nstart;
        wait_start(20, s);
        core_reply(2, 0, 1, '0);
        wait_start(20, s);
        core_reply(3, 1, 1, C2);
        wait_out(20, o);
        check_eq("t3_status", out_status, 2'b10);
        check_eq("t3_data", out_data, 0);
        check_eq("t3_starts", nstart - base, 2);
        handshake();
        check_eq("t3_err", err_count, 1);

        // Silent core: timeout 17 cycles after the start pulse.
        do_timeout(s, o);
        check_eq("t4_latency", o - s, 17);
        check_eq("t4_status", out_status, 2'b11);
        check_eq("t4_data", out_data, 0);
        handshake();
        check_eq("t4_err", err_count, 2);

        // Result on the very last timer cycle still counts as a result.
        send_req(K1, P1);
        wait_start(20, s);
        core_reply(15, 1, 0, C1);
        wait_out(40, o);
        check_eq("t4b_latency", o - s, 17);
        check_eq("t4b_status", out_status, 2'b00);
        check_eq("t4b_data", out_data, C1);
        handshake();
        check_eq("t4b_err", err_count, 2);

        // Back-pressure with a second request waiting.
        send_req(K1, P1);
        wait_start(20, s);
        core_reply(2, 1, 0, C1);
        wait_out(20, o);
        in_key = K2; in_plain = P2; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            check_eq("t5_hold_valid", out_valid, 1);
            check_eq("t5_hold_data", out_data, C1);
            check_eq("t5_hold_status", out_status, 2'b00);
            check_eq("t5_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("t5_idle_ready", in_ready, 1);
        check_eq("t5_idle_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_second_start", core_start, 1);
        check_eq("t5_second_key", core_key, K2);
        step();
        core_reply(1, 1, 0, C2);
        wait_out(20, o);
        check_eq("t5_second_data", out_data, C2);
        handshake();

        // Busy core holds off the start pulse by exactly 5 cycles.
        core_busy = 1'b1;
        send_req(K1, P1);
        acc = cyc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_busy_nostart", core_start, 0);
            step();
        end
        core_busy = 1'b0;
        wait_start(20, s);
        check_eq("t6_busy_delay", s - acc, 5);
        core_reply(1, 1, 0, C1);
        wait_out(20, o);
        check_eq("t6_busy_data", out_data, C1);
        handshake();

        // Error counter saturation.
        do_timeout(s, o);
        handshake();
        check_eq("sat_err_3", err_count, 3);
        do_timeout(s, o);
        handshake();
        check_eq("sat_err_hold", err_count, 3);

        // Reset in WAIT, then a late response that must be ignored.
        send_req(K2, P2);
        wait_start(20, s);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_core_start", core_start, 0);
        check_eq("midrst_core_key", core_key, 0);
        check_eq("midrst_core_plain", core_plain, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_out_status", out_status, 0);
        check_eq("midrst_err", err_count, 0);
        check_eq("midrst_idle", in_ready, 1);
        core_valid = 1'b1; core_ciphertext = C2;
        seen_out = 1'b0; seen_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) begin core_valid = 1'b0; core_ciphertext = '0; end
            @(negedge clk);
            seen_out   = seen_out | out_valid;
            seen_start = seen_start | core_start;
        end
        check_eq("late_no_out", seen_out, 0);
        check_eq("late_no_start", seen_start, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
